// File: rtl/serial_par_align_pkg.sv
// Shared constants and state encoding for the serial lane aligner.
package serial_par_align_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_par_align_comma_detect.sv
// Combinational COM / IDL match on the current 8-bit window.
module comma_detect
    import serial_par_align_pkg::*;
(
    input  logic [7:0] window,
    output logic       is_com,
    output logic       is_idl
);

    assign is_com = (window == COM);
    assign is_idl = (window == IDL);

endmodule

// File: rtl/serial_par_align.sv
// Serial-to-parallel byte aligner: locks on four consecutive COM bytes, then emits payload.
// Optional byte_cnt output is enabled with the SERPAR_BYTE_CNT_EN macro.
module serial_par_align
    import serial_par_align_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
`ifdef SERPAR_BYTE_CNT_EN
    output logic       active_out,
    output logic [7:0] byte_cnt
`else
    output logic       active_out
`endif
);

    state_t     state, state_next;
    logic [6:0] sr;
    logic [7:0] w;
    logic [2:0] cnt, cnt_next;
    logic [2:0] bc_cnt, bc_next;
    logic [7:0] data_next;
    logic       valid_next;
    logic       is_com, is_idl;
    logic       boundary;

    // Only the low 7 bits of the shift register ever reach the window.
    assign w        = {sr, data_in};
    assign boundary = (cnt == 3'd7);

    comma_detect u_comma_detect (
        .window (w),
        .is_com (is_com),
        .is_idl (is_idl)
    );

`ifdef SERPAR_BYTE_CNT_EN
    logic [7:0] byte_cnt_next;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bc_next    = bc_cnt;
        data_next  = data_out;
        valid_next = valid_out;
`ifdef SERPAR_BYTE_CNT_EN
        byte_cnt_next = byte_cnt;
`endif
        case (state)
            SEARCH: begin
                if (is_com) begin
                    state_next = LOCKING;
                    cnt_next   = '0;
                    bc_next    = 3'd1;
                end
            end
            LOCKING: begin
                cnt_next = cnt + 3'd1;
                if (boundary) begin
                    if (!is_com) begin
                        state_next = SEARCH;
                        bc_next    = '0;
                    end else if (bc_cnt == 3'd3) begin
                        state_next = ACTIVE;
                        bc_next    = 3'd4;
                    end else begin
                        bc_next = bc_cnt + 3'd1;
                    end
                end
            end
            ACTIVE: begin
                cnt_next = cnt + 3'd1;
                if (boundary) begin
                    data_next  = w;
                    valid_next = !is_com && !is_idl;
`ifdef SERPAR_BYTE_CNT_EN
                    if (!is_com && !is_idl && byte_cnt != '1)
                        byte_cnt_next = byte_cnt + 8'd1;
`endif
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            sr         <= '0;
            cnt        <= '0;
            bc_cnt     <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            active_out <= 1'b0;
`ifdef SERPAR_BYTE_CNT_EN
            byte_cnt   <= '0;
`endif
        end else begin
            state      <= state_next;
            sr         <= w[6:0];
            cnt        <= cnt_next;
            bc_cnt     <= bc_next;
            data_out   <= data_next;
            valid_out  <= valid_next;
            active_out <= (state_next == ACTIVE);
`ifdef SERPAR_BYTE_CNT_EN
            byte_cnt   <= byte_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_serial_par_align.sv
// Scoreboard bench for serial_par_align; the bit-stream reference model predicts outputs per edge.
module tb_serial_par_align;

    localparam logic [7:0] COM_B = 8'hBC;
    localparam logic [7:0] IDL_B = 8'h7C;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;
`ifdef SERPAR_BYTE_CNT_EN
    logic [7:0] byte_cnt;
`endif

    serial_par_align dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
`ifdef SERPAR_BYTE_CNT_EN
        .active_out (active_out),
        .byte_cnt   (byte_cnt)
`else
        .active_out (active_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       act;
        logic       vld;
        logic [7:0] dat;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_cyc   = 0;

    // Reference model: bit position since reset, anchor of the first COM,
    // number of COMs seen on the byte grid, and last emitted byte.
    int         m_mode;   // 0 hunting, 1 counting COMs, 2 locked
    int         m_idx;
    int         m_anchor;
    int         m_coms;
    logic [7:0] m_win;
    logic [7:0] m_dat;
    logic       m_vld;
    int         m_bytes;

    task automatic model_step(input logic r, input logic b);
        logic [7:0] wv;
        exp_t e;
        if (r) begin
            m_mode = 0; m_idx = 0; m_anchor = 0; m_coms = 0;
            m_win = 8'h00; m_dat = 8'h00; m_vld = 1'b0; m_bytes = 0;
        end else begin
            wv = (m_win << 1) | {7'd0, b};
            m_idx++;
            if (m_mode == 0) begin
                if (wv == COM_B) begin
                    m_mode = 1; m_anchor = m_idx; m_coms = 1;
                end
            end else if ((m_idx - m_anchor) % 8 == 0) begin
                if (m_mode == 1) begin
                    if (wv == COM_B) begin
                        m_coms++;
                        if (m_coms == 4) m_mode = 2;
                    end else begin
                        m_mode = 0;
                    end
                end else begin
                    m_dat = wv;
                    m_vld = (wv != COM_B) && (wv != IDL_B);
                    if (m_vld && m_bytes < 255) m_bytes++;
                end
            end
            m_win = wv;
        end
        e.act = (m_mode == 2);
        e.vld = m_vld;
        e.dat = m_dat;
        e.cnt = 8'(m_bytes);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic b);
        reset   = r;
        data_in = b;
        model_step(r, b);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(1'b0, v[i]);
    endtask

    task automatic send_com(input int n);
        for (int i = 0; i < n; i++) send_byte(COM_B);
    endtask

    task automatic payload(input int n, input bit mix_ctrl);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = 8'($urandom_range(0, 255));
            if (mix_ctrl && $urandom_range(0, 7) == 0)
                v = $urandom_range(0, 1) ? COM_B : IDL_B;
            else if (v == COM_B || v == IDL_B)
                v = 8'hA5;
            send_byte(v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cyc++;
            n_total++;
            if (active_out === e.act && valid_out === e.vld && data_out === e.dat
`ifdef SERPAR_BYTE_CNT_EN
                && byte_cnt === e.cnt
`endif
               )
                n_pass++;
            else
                $display("FAIL out cyc=%0d got act=%b vld=%b dat=%h cnt=%h required act=%b vld=%b dat=%h cnt=%h",
                         n_cyc, active_out, valid_out, data_out,
`ifdef SERPAR_BYTE_CNT_EN
                         byte_cnt,
`else
                         e.cnt,
`endif
                         e.act, e.vld, e.dat, e.cnt);
        end
    end

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;

        // Reset state, then junk 101 and four COMs to lock.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        send_com(4);

        // Payload, IDL and COM while locked.
        send_byte(8'hA5);
        send_byte(IDL_B);
        send_byte(COM_B);
        payload(20, 1'b1);

        // Reset mid-byte, then a failed lock attempt and a good one.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        send_com(3);
        send_byte(8'h00);
        send_byte(8'h00);
        send_com(4);
        payload(10, 1'b1);

        // Random junk before lock, then enough payload to saturate byte_cnt.
        step(1'b1, 1'b0);
        for (int i = 0; i < int'($urandom_range(0, 20)); i++)
            step(1'b0, 1'($urandom_range(0, 1)));
        send_com(4);
        payload(300, 1'b0);
        payload(30, 1'b1);

        // Free-running random bit stream after a reset.
        step(1'b1, 1'b0);
        for (int i = 0; i < 400; i++)
            step(1'b0, 1'($urandom_range(0, 1)));

        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_par_align.md
SERIAL_PAR_ALIGN -- requirements
Module: serial_par_align

Interface
REQ-001 SHALL have no parameters; COM=8'hBC and IDL=8'h7C are fixed constants.
REQ-002 SHALL have port clk, input, 1 bit: the lane bit clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port data_in, input, 1 bit: serial lane bit, MSB of each byte first, one bit per clk.
REQ-005 SHALL have port data_out, output, 8 bits: last aligned byte, registered.
REQ-006 SHALL have port valid_out, output, 1 bit: data_out carries payload (not COM, not IDL).
REQ-007 SHALL have port active_out, output, 1 bit: the lane is byte-aligned and in the ACTIVE state.

Function
REQ-008 SHALL shift every cycle: sr <= {sr[6:0], data_in}; window w = {sr[6:0], data_in}.
REQ-009 SHALL implement states SEARCH, LOCKING and ACTIVE, with a 3-bit bit counter cnt and a 3-bit COM counter bc_cnt.
REQ-010 In SEARCH, on any edge where w==COM: go to LOCKING, set cnt<=0 and bc_cnt<=1; otherwise stay in SEARCH.
REQ-011 In LOCKING and ACTIVE, cnt SHALL increment by 1 each cycle modulo 8; a byte boundary is an edge with cnt==7.
REQ-012 LOCKING boundary with w==COM and bc_cnt==3: go to ACTIVE, with bc_cnt<=4.
REQ-013 LOCKING boundary with w==COM and bc_cnt<3: increment bc_cnt.
REQ-014 LOCKING boundary with w!=COM: go to SEARCH with bc_cnt<=0; the same edge does not re-check w for COM.
REQ-015 ACTIVE boundary: data_out<=w and valid_out<=(w!=COM && w!=IDL); both hold until the next boundary.
REQ-016 Latency SHALL be 1 cycle: data_out/valid_out update on the edge that samples the byte's 8th bit.
REQ-017 ACTIVE SHALL persist until reset, with no loss-of-lock detection; COM bytes in ACTIVE only deassert valid_out.
REQ-018 active_out SHALL be a register set on the same edge as the LOCKING->ACTIVE transition.
REQ-019 data_out and valid_out SHALL NOT change in SEARCH or LOCKING; they stay 8'h00 and 0.

Reset
REQ-020 When reset=1 at an edge, the block SHALL set: state=SEARCH, sr=0, cnt=0, bc_cnt=0, data_out=8'h00, valid_out=0, active_out=0.
REQ-021 Reset SHALL take priority over all transitions, including mid-ACTIVE and mid-boundary.
REQ-022 The first cycle after reset deasserts SHALL be treated as a SEARCH cycle.

Configuration
REQ-023 With macro SERPAR_BYTE_CNT_EN defined, the block SHALL add output port byte_cnt, 8 bits, reset to 0.
REQ-024 byte_cnt SHALL increment on each ACTIVE boundary with valid payload and saturate at 8'hFF.
REQ-025 Without SERPAR_BYTE_CNT_EN, the port and counter SHALL be absent and all other behaviour is identical.

Structure
REQ-026 A shared package SHALL hold COM, IDL and the state encoding (SEARCH=2'd0, LOCKING=2'd1, ACTIVE=2'd2).
REQ-027 SHALL treat state encoding 2'd3 as illegal and go to SEARCH on the next edge.
REQ-028 A sub-module comma_detect SHALL compare the window against COM and IDL (combinational only); all state stays in serial_par_align.

Verification
REQ-029 Reset, then 3 junk bits 101, then COM x4 -> active_out=1 on the edge sampling the last bit of the 4th COM; valid_out=0.
REQ-030 Active lane, send 8'hA5 -> one cycle after its last bit, data_out=8'hA5 and valid_out=1, held for 8 cycles.
REQ-031 Active lane, send 8'h7C then 8'hBC -> data_out=7C with valid_out=0, then data_out=BC with valid_out=0; active_out stays 1.
REQ-032 Send COM x3 then 8'h00 -> state returns to SEARCH, active_out stays 0; a following COM x4 achieves lock.
REQ-033 Assert reset mid-byte in ACTIVE -> next cycle all outputs are 0; relock requires 4 fresh COM bytes.
REQ-034 With SERPAR_BYTE_CNT_EN, send 300 payload bytes -> byte_cnt=8'hFF; COM and IDL bytes do not count.
